moving_average_cfg_sequencer: RTL

// Sequences reconfiguration of the lock-in X/Y moving_average_wrapper: latches a new filter length/order from
// the host, holds the filter in reset, waits for ready, applies the settings, then masks output until windows refill.

---
 rtl/moving_average_ctrl_pkg.sv | 40 ++++
 rtl/moving_average_cfg_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/moving_average_ctrl_pkg.sv
// Shared types, defaults and width helpers for the lock-in moving-average filter control path.
// The register bank imports the DEFAULT_* values so host readback matches what the sequencer applies.
package moving_average_ctrl_pkg;

   typedef enum logic [1:0] {
      RESET_MA   = 2'd0,
      WAIT_READY = 2'd1,
      SETTLE     = 2'd2,
      RUN        = 2'd3
   } ma_state_e;

   localparam int unsigned DEF_MAX_DECIMATION   = 32'd1024;
   localparam int unsigned DEF_MAX_CASCADED_MAS = 32'd3;
   localparam int unsigned DEF_RESET_CYCLES     = 32'd4;
   localparam int unsigned DEFAULT_LENGTH       = 32'd16;
   localparam int unsigned DEFAULT_ORDER        = 32'd1;

   function automatic int unsigned len_width(input int unsigned max_decimation);
      return $clog2(max_decimation) + 1;
   endfunction

   function automatic int unsigned ord_width(input int unsigned max_cascaded);
      return $clog2(max_cascaded) + 1;
   endfunction

   // Settle target is length * order, so its width is the sum of both operand widths.
   function automatic int unsigned settle_width(input int unsigned max_decimation,
                                                input int unsigned max_cascaded);
      return len_width(max_decimation) + ord_width(max_cascaded);
   endfunction

   function automatic logic cfg_in_range(input logic [31:0] length,
                                         input logic [31:0] order,
                                         input logic [31:0] max_len,
                                         input logic [31:0] max_ord);
      return (length >= 32'd1) && (length <= max_len) &&
             (order  >= 32'd1) && (order  <= max_ord);
   endfunction

endpackage

// File: rtl/moving_average_cfg_sequencer.sv
// Reconfiguration sequencer for the X/Y moving-average filter pair: holds the filter in reset,
// waits for ready, applies length/order, and masks the output strobe until every window has refilled.
module moving_average_cfg_sequencer #(
   parameter int unsigned MAX_DECIMATION   = moving_average_ctrl_pkg::DEF_MAX_DECIMATION,
   parameter int unsigned MAX_CASCADED_MAs = moving_average_ctrl_pkg::DEF_MAX_CASCADED_MAS,
   parameter int unsigned DEFAULT_LENGTH   = moving_average_ctrl_pkg::DEFAULT_LENGTH,
   parameter int unsigned DEFAULT_ORDER    = moving_average_ctrl_pkg::DEFAULT_ORDER,
   parameter int unsigned RESET_CYCLES     = moving_average_ctrl_pkg::DEF_RESET_CYCLES,
   localparam int unsigned LW = moving_average_ctrl_pkg::len_width(MAX_DECIMATION),
   localparam int unsigned OW = moving_average_ctrl_pkg::ord_width(MAX_CASCADED_MAs)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [LW-1:0] cfg_length,
   input  logic [OW-1:0] cfg_order,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   output logic          cfg_error,
   output logic          cfg_done,
   input  logic          in_valid,
   output logic          ma_data_in_valid,
   output logic          ma_reset,
   input  logic          ma_ready,
   output logic [LW-1:0] ma_length,
   output logic [OW-1:0] ma_order,
   input  logic          ma_data_out_valid,
   output logic          data_out_valid,
   output logic          settling
);
   import moving_average_ctrl_pkg::*;

   localparam int unsigned SW        = settle_width(MAX_DECIMATION, MAX_CASCADED_MAs);
   localparam logic [SW-1:0] HOLD_LAST = SW'(RESET_CYCLES - 32'd1);
   localparam logic [SW-1:0] CNT_ONE   = SW'(32'd1);
   localparam logic [LW-1:0] LEN_RST   = LW'(DEFAULT_LENGTH);
   localparam logic [OW-1:0] ORD_RST   = OW'(DEFAULT_ORDER);

   ma_state_e     state_q, state_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] ma_length_q, ma_length_d;
   logic [OW-1:0] ma_order_q, ma_order_d;
   logic          cfg_error_q, cfg_error_d;
   logic          cfg_done_s;
   logic          live_s;
   logic          accept_s;
   logic          range_ok_s;
   logic [SW-1:0] settle_target_s;

   assign live_s          = (state_q == SETTLE) || (state_q == RUN);
   assign accept_s        = cfg_valid && live_s;
   assign range_ok_s      = cfg_in_range(32'(cfg_length), 32'(cfg_order),
                                         32'(MAX_DECIMATION), 32'(MAX_CASCADED_MAs));
   assign settle_target_s = SW'(ma_length_q) * SW'(ma_order_q);

   assign cfg_ready         = live_s;
   assign cfg_error         = cfg_error_q;
   assign cfg_done          = cfg_done_s;
   assign ma_reset          = (state_q == RESET_MA);
   assign ma_data_in_valid  = live_s && in_valid;
   assign data_out_valid    = (state_q == RUN) && ma_data_out_valid;
   assign settling          = (state_q != RUN);
   assign ma_length         = ma_length_q;
   assign ma_order          = ma_order_q;

   // Next-state logic; cnt counts up during the reset hold and down during the settle count.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ma_length_d = ma_length_q;
      ma_order_d  = ma_order_q;
      cfg_error_d = 1'b0;
      cfg_done_s  = 1'b0;
      case (state_q)
         RESET_MA: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = WAIT_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         WAIT_READY: begin
            if (ma_ready) begin
               state_d = SETTLE;
               cnt_d   = settle_target_s;
            end else begin
               state_d = WAIT_READY;
            end
         end
         SETTLE, RUN: begin
            cfg_error_d = accept_s && !range_ok_s;
            if (accept_s && range_ok_s) begin
               state_d     = RESET_MA;
               cnt_d       = '0;
               ma_length_d = cfg_length;
               ma_order_d  = cfg_order;
            end else if (!ma_ready) begin
               state_d = RESET_MA;
               cnt_d   = '0;
            end else if ((state_q == SETTLE) && !cfg_error_q) begin
               // Completion is held off while a reject pulse is out so done and error never coincide.
               if (cnt_q == '0) begin
                  state_d    = RUN;
                  cfg_done_s = 1'b1;
               end else if (in_valid) begin
                  if (cnt_q == CNT_ONE) begin
                     state_d    = RUN;
                     cnt_d      = '0;
                     cfg_done_s = 1'b1;
                  end else begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = RESET_MA;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter, applied configuration and reject pulse registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RESET_MA;
         cnt_q       <= '0;
         ma_length_q <= LEN_RST;
         ma_order_q  <= ORD_RST;
         cfg_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ma_length_q <= ma_length_d;
         ma_order_q  <= ma_order_d;
         cfg_error_q <= cfg_error_d;
      end
   end

endmodule
